// File: rtl/field_ctrl.sv
// Bit-field extract/insert sequencer driving the registered mask unit.
// Define FIELD_CTRL_INSERT_EN to build the insert path (second pass and merge).
module field_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic [7:0] req_src,
    input  logic [7:0] req_dst,
    input  logic [2:0] req_rot,
    input  logic [2:0] req_len,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [7:0] mu_mask_in,
    output logic [2:0] mu_L_select,
    input  logic [7:0] mu_mask_out
);

    typedef enum logic [2:0] {
        StIdle,
        StPass1,
        StCapt1,
`ifdef FIELD_CTRL_INSERT_EN
        StPass2,
        StCapt2,
`endif
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] src_q;
    logic [2:0] rot_q;
    logic [2:0] len_q;
    logic [7:0] field_q;
    logic       accept;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] r);
        logic [15:0] d;
        d = {x, x} << r;
        return d[15:8];
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] r);
        logic [15:0] d;
        d = {x, x} >> r;
        return d[7:0];
    endfunction

    assign accept = (state_q == StIdle) && req_valid;

`ifdef FIELD_CTRL_INSERT_EN
    logic       op_q;
    logic [7:0] dst_q;
    logic [7:0] res_q;
    logic [7:0] merge_mask;

    assign merge_mask = rotl8(mu_mask_out, rot_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= 1'b0;
            dst_q <= 8'h00;
            res_q <= 8'h00;
        end else begin
            if (accept) begin
                op_q  <= req_op;
                dst_q <= req_dst;
            end
            if (state_q == StCapt1 && !op_q) begin
                res_q <= mu_mask_out;
            end
            if (state_q == StCapt2) begin
                res_q <= (dst_q & ~merge_mask) | (rotl8(field_q, rot_q) & merge_mask);
            end
        end
    end

    assign res_data = res_q;
`else
    logic op_q;
    logic unused_insert;

    assign op_q          = 1'b0;
    assign unused_insert = ^{req_op, req_dst};
    // Extract-only: the captured field is the result and only changes on CAPT1->DONE.
    assign res_data      = field_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            src_q   <= 8'h00;
            rot_q   <= 3'd0;
            len_q   <= 3'd0;
            field_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_q <= req_src;
                rot_q <= req_rot;
                len_q <= req_len;
            end
            if (state_q == StCapt1) begin
                field_q <= mu_mask_out;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = StPass1;
            StPass1: state_d = StCapt1;
`ifdef FIELD_CTRL_INSERT_EN
            StCapt1: state_d = op_q ? StPass2 : StDone;
            StPass2: state_d = StCapt2;
            StCapt2: state_d = StDone;
`else
            StCapt1: state_d = StDone;
`endif
            StDone:  if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Mask unit inputs depend only on state and latched request fields.
    always_comb begin
        req_ready   = (state_q == StIdle);
        res_valid   = (state_q == StDone);
        mu_mask_in  = 8'h00;
        mu_L_select = 3'd0;
        if (state_q == StPass1) begin
            mu_mask_in  = op_q ? src_q : rotr8(src_q, rot_q);
            mu_L_select = len_q;
        end
`ifdef FIELD_CTRL_INSERT_EN
        if (state_q == StPass2) begin
            mu_mask_in  = 8'hFF;
            mu_L_select = len_q;
        end
`endif
    end

endmodule

// File: tb/tb_field_ctrl.sv
// Self-checking bench for field_ctrl with a behavioural mask unit and field model.
module tb_field_ctrl;

`ifdef FIELD_CTRL_INSERT_EN
    localparam bit Ins = 1'b1;
`else
    localparam bit Ins = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_op = 1'b0;
    logic [7:0] req_src = 8'h00;
    logic [7:0] req_dst = 8'h00;
    logic [2:0] req_rot = 3'd0;
    logic [2:0] req_len = 3'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [7:0] mu_mask_in;
    logic [2:0] mu_L_select;
    logic [7:0] mu_mask_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    field_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .req_rot    (req_rot),
        .req_len    (req_len),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .mu_mask_in (mu_mask_in),
        .mu_L_select(mu_L_select),
        .mu_mask_out(mu_mask_out)
    );

    // Mask unit: keeps the low L bits of mask_in (L=0 means all 8), one cycle registered.
    function automatic logic [7:0] len_mask(input logic [2:0] l);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < ((l == 3'd0) ? 8 : int'(l)); i++) m[i] = 1'b1;
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mu_mask_out <= 8'h00;
        else        mu_mask_out <= mu_mask_in & len_mask(mu_L_select);
    end

    // Field semantics by bit positions: field bit i lives at byte bit (i + rot) mod 8.
    function automatic logic [7:0] rot_right(input logic [7:0] x, input logic [2:0] r);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = x[(i + int'(r)) % 8];
        return y;
    endfunction

    function automatic logic [7:0] model(input logic op, input logic [7:0] src,
                                         input logic [7:0] dst, input logic [2:0] rot,
                                         input logic [2:0] len);
        logic [7:0] r;
        int w;
        w = (len == 3'd0) ? 8 : int'(len);
        if (op && Ins) begin
            r = dst;
            for (int i = 0; i < w; i++) r[(i + int'(rot)) % 8] = src[i];
        end else begin
            r = 8'h00;
            for (int i = 0; i < w; i++) r[i] = src[(i + int'(rot)) % 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Starts and ends just after a falling edge with the DUT idle.
    task automatic run_check(input logic op, input logic [7:0] src, input logic [7:0] dst,
                             input logic [2:0] rot, input logic [2:0] len, input int stall,
                             input logic [7:0] exp_data, input logic [7:0] exp_p1);
        int exp_lat;
        int lat;
        exp_lat   = (op && Ins) ? 5 : 3;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        req_rot   = rot;
        req_len   = len;
        req_valid = 1'b1;
        res_ready = 1'b0;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_src   = 8'($urandom);
        req_dst   = 8'($urandom);
        req_rot   = 3'($urandom);
        req_len   = 3'($urandom);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("pass1_mask_in", {24'd0, mu_mask_in}, {24'd0, exp_p1});
                check("pass1_L_select", {29'd0, mu_L_select}, {29'd0, len});
                check("busy_req_ready", {31'd0, req_ready}, 32'd0);
            end
            if (k == 2) check("capt1_mask_in", {24'd0, mu_mask_in}, 32'd0);
            if (k == 3 && op && Ins) begin
                check("pass2_mask_in", {24'd0, mu_mask_in}, 32'hFF);
                check("pass2_L_select", {29'd0, mu_L_select}, {29'd0, len});
            end
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, exp_lat);
        check("res_data", {24'd0, res_data}, {24'd0, exp_data});
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_data", {24'd0, res_data}, {24'd0, exp_data});
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("post_res_valid", {31'd0, res_valid}, 32'd0);
        check("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic       op;
        logic [7:0] src;
        logic [7:0] dst;
        logic [2:0] rot;
        logic [2:0] len;
        logic [7:0] data_on;
        logic [7:0] data_off;
        logic [7:0] p1_on;
        logic [7:0] p1_off;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       op;
        logic [7:0] src, dst;
        logic [2:0] rot, len;

        vecs[0] = '{1'b0, 8'hB6, 8'h00, 3'd2, 3'd3, 8'h05, 8'h05, 8'hAD, 8'hAD};
        vecs[1] = '{1'b0, 8'h5A, 8'h00, 3'd0, 3'd0, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        vecs[2] = '{1'b1, 8'h05, 8'hFF, 3'd4, 3'd3, 8'hDF, 8'h00, 8'h05, 8'h50};
        vecs[3] = '{1'b1, 8'h0F, 8'h00, 3'd6, 3'd4, 8'hC3, 8'h0C, 8'h0F, 8'h3C};
        vecs[4] = '{1'b0, 8'h81, 8'h00, 3'd7, 3'd2, 8'h03, 8'h03, 8'h03, 8'h03};

        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {24'd0, res_data}, 32'd0);
        check("rst_mask_in", {24'd0, mu_mask_in}, 32'd0);
        check("rst_L_select", {29'd0, mu_L_select}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_check(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].rot, vecs[i].len, 0,
                      Ins ? vecs[i].data_on : vecs[i].data_off,
                      Ins ? vecs[i].p1_on : vecs[i].p1_off);
        end

        // Long back-pressure, then a back-to-back request right after release.
        run_check(1'b1, 8'h05, 8'hFF, 3'd4, 3'd3, 10, Ins ? 8'hDF : 8'h00,
                  Ins ? 8'h05 : 8'h50);
        run_check(1'b0, 8'hB6, 8'h00, 3'd2, 3'd3, 0, 8'h05, 8'hAD);

        for (int n = 0; n < 40; n++) begin
            op  = 1'($urandom);
            src = 8'($urandom);
            dst = 8'($urandom);
            rot = 3'($urandom);
            len = 3'($urandom);
            run_check(op, src, dst, rot, len, $urandom_range(0, 3), model(op, src, dst, rot, len),
                      (op && Ins) ? src : rot_right(src, rot));
        end

        // Reset during the second pass (or held DONE when insert is not built).
        req_op    = 1'b1;
        req_src   = 8'h0F;
        req_dst   = 8'h00;
        req_rot   = 3'd6;
        req_len   = 3'd4;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_mask_in", {24'd0, mu_mask_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("midrst_no_result", {31'd0, res_valid}, 32'd0);
        end
        run_check(1'b0, 8'h5A, 8'h00, 3'd0, 3'd0, 0, 8'h5A, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
